// File: rtl/alu_issue_ctrl_if.sv
// Dispatch request, ALU operand/result and writeback result signals of alu_issue_ctrl.
// master = the issue controller, slave = dispatch/ALU/writeback environment.
interface alu_issue_ctrl_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic [4:0]       aluop;
    logic [31:0]      aluin1;
    logic [31:0]      aluin2;
    logic [31:0]      aluout;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        input  in_valid, in_op, in_a, in_b, in_tag, aluout, out_ready,
        output in_ready, aluop, aluin1, aluin2, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        output in_valid, in_op, in_a, in_b, in_tag, aluout, out_ready,
        input  in_ready, aluop, aluin1, aluin2, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// In-order ALU issue controller: request FIFO, fixed-latency in-flight tracking,
// result buffer and credit flow control so no ALU result is ever dropped.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    function automatic logic op_legal(input logic [4:0] op);
        return op inside {[5'd0:5'd7], 5'd16, 5'd17, 5'd18, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30};
    endfunction

    // request FIFO
    logic [4:0]       rq_op_q  [DEPTH];
    logic [31:0]      rq_a_q   [DEPTH];
    logic [31:0]      rq_b_q   [DEPTH];
    logic [TAG_W-1:0] rq_tag_q [DEPTH];
    logic             rq_err_q [DEPTH];
    ptr_t             rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
    logic [AW-1:0]    rq_head;
    logic             rq_full, rq_empty;

    // in-flight pipe, stage k holds the op issued k cycles earlier
    logic             pv_q [1:ALU_LAT];
    logic [TAG_W-1:0] pt_q [1:ALU_LAT];
    logic             pe_q [1:ALU_LAT];

    // result buffer
    logic [31:0]      rb_res_q [DEPTH];
    logic [TAG_W-1:0] rb_tag_q [DEPTH];
    logic             rb_err_q [DEPTH];
    ptr_t             rb_wr_q, rb_wr_d, rb_rd_q, rb_rd_d;
    logic [AW-1:0]    rb_head;
    logic             rb_empty;

    ptr_t             credits_q, credits_d;
    logic             push, issue, rb_push, pop;

    assign rq_head  = rq_rd_q[AW-1:0];
    assign rq_empty = (rq_wr_q == rq_rd_q);
    assign rq_full  = (rq_wr_q[AW] != rq_rd_q[AW]) && (rq_wr_q[AW-1:0] == rq_rd_q[AW-1:0]);

    assign rb_head  = rb_rd_q[AW-1:0];
    assign rb_empty = (rb_wr_q == rb_rd_q);

    assign bus.in_ready = !rq_full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign issue        = !rst && !rq_empty && (credits_q < DEPTH_P);
    assign rb_push      = pv_q[ALU_LAT];
    assign pop          = bus.out_valid && bus.out_ready;

    always_comb begin
        bus.aluop  = '0;
        bus.aluin1 = '0;
        bus.aluin2 = '0;
        if (issue && !rq_err_q[rq_head]) begin
            bus.aluop  = rq_op_q[rq_head];
            bus.aluin1 = rq_a_q[rq_head];
            bus.aluin2 = rq_b_q[rq_head];
        end
    end

    always_comb begin
        rq_wr_d   = rq_wr_q + ptr_t'(push);
        rq_rd_d   = rq_rd_q + ptr_t'(issue);
        rb_wr_d   = rb_wr_q + ptr_t'(rb_push);
        rb_rd_d   = rb_rd_q + ptr_t'(pop);
        credits_d = credits_q + ptr_t'(issue) - ptr_t'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rq_wr_q   <= '0;
            rq_rd_q   <= '0;
            rb_wr_q   <= '0;
            rb_rd_q   <= '0;
            credits_q <= '0;
        end else begin
            rq_wr_q   <= rq_wr_d;
            rq_rd_q   <= rq_rd_d;
            rb_wr_q   <= rb_wr_d;
            rb_rd_q   <= rb_rd_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rq_op_q[rq_wr_q[AW-1:0]]  <= bus.in_op;
            rq_a_q[rq_wr_q[AW-1:0]]   <= bus.in_a;
            rq_b_q[rq_wr_q[AW-1:0]]   <= bus.in_b;
            rq_tag_q[rq_wr_q[AW-1:0]] <= bus.in_tag;
            rq_err_q[rq_wr_q[AW-1:0]] <= !op_legal(bus.in_op);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i <= ALU_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pt_q[i] <= '0;
                pe_q[i] <= 1'b0;
            end
        end else begin
            pv_q[1] <= issue;
            pt_q[1] <= rq_tag_q[rq_head];
            pe_q[1] <= rq_err_q[rq_head];
            for (int unsigned i = 2; i <= ALU_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    // credits bound occupancy, so the buffer needs no full check
    always_ff @(posedge clk) begin
        if (rb_push && !rst) begin
            rb_res_q[rb_wr_q[AW-1:0]] <= pe_q[ALU_LAT] ? '0 : bus.aluout;
            rb_tag_q[rb_wr_q[AW-1:0]] <= pt_q[ALU_LAT];
            rb_err_q[rb_wr_q[AW-1:0]] <= pe_q[ALU_LAT];
        end
    end

    assign bus.out_valid  = !rb_empty;
    assign bus.out_result = rb_empty ? '0 : rb_res_q[rb_head];
    assign bus.out_tag    = rb_empty ? '0 : rb_tag_q[rb_head];
    assign bus.out_err    = !rb_empty && rb_err_q[rb_head];
endmodule
